// File: rtl/lfsr_stream_cipher_if.sv
// Word-stream handshake bundle for the LFSR stream cipher: an input channel
// (plaintext or ciphertext in) and an output channel (XORed result out).
interface lfsr_stream_cipher_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Producer/consumer side: offers input words and accepts results.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // Cipher side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream cipher: each accepted word is XORed with DATA_W keystream bits
// drawn from a right-shifting Galois LFSR, one bit per GEN cycle. The
// keystream runs on across words, so the same seed both encrypts and decrypts.
module lfsr_stream_cipher #(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(16'hB400),
  parameter int unsigned       DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed_in,
  lfsr_stream_cipher_if.slave   bus,
  output logic                  seeded,
  output logic                  seed_err,
  output logic [15:0]           word_cnt
);

  localparam int unsigned      StepW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [StepW-1:0] LastStep = StepW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StGen, StOut} state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [DATA_W-1:0]   ks_q, ks_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [StepW-1:0]    step_q, step_d;
  logic                seeded_q, seeded_d;
  logic                seed_err_q, seed_err_d;
  logic [15:0]         word_cnt_q, word_cnt_d;
  logic                in_ready;

  assign in_ready      = (state_q == StIdle) && seeded_q && !seed_load;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_data  = out_data_q;
  assign seeded        = seeded_q;
  assign seed_err      = seed_err_q;
  assign word_cnt      = word_cnt_q;

  // Next-state: seed_load overrides the handshake FSM; LFSR only steps in GEN.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    ks_d       = ks_q;
    data_d     = data_q;
    out_data_d = out_data_q;
    step_d     = step_q;
    seeded_d   = seeded_q;
    seed_err_d = seed_err_q;
    word_cnt_d = word_cnt_q;

    if (seed_load) begin
      // Any in-flight word is dropped without counting it.
      state_d = StIdle;
      if (seed_in != '0) begin
        lfsr_d     = seed_in;
        seeded_d   = 1'b1;
        seed_err_d = 1'b0;
        word_cnt_d = '0;
      end else begin
        // An all-zero LFSR would lock up, so refuse the seed and keep the state.
        seeded_d   = 1'b0;
        seed_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready) begin
            data_d  = bus.in_data;
            step_d  = '0;
            state_d = StGen;
          end
        end
        StGen: begin
          ks_d[step_q] = lfsr_q[0];
          lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
          step_d       = step_q + StepW'(1);
          if (step_q == LastStep) begin
            out_data_d = data_q ^ ks_d;
            state_d    = StOut;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            word_cnt_d = word_cnt_q + 16'd1;
            state_d    = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      lfsr_q     <= '0;
      ks_q       <= '0;
      data_q     <= '0;
      out_data_q <= '0;
      step_q     <= '0;
      seeded_q   <= 1'b0;
      seed_err_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      ks_q       <= ks_d;
      data_q     <= data_d;
      out_data_q <= out_data_d;
      step_q     <= step_d;
      seeded_q   <= seeded_d;
      seed_err_q <= seed_err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Directed-plus-random bench for lfsr_stream_cipher at default parameters.
// Expected words come from an arithmetic keystream model of the Galois LFSR.
module tb_lfsr_stream_cipher;

  localparam int unsigned DW       = 8;
  localparam int unsigned LW       = 16;
  localparam int unsigned TAPS_INT = 32'hB400;

  logic          clk = 1'b0;
  logic          rst;
  logic          seed_load;
  logic [LW-1:0] seed_in;
  logic          seeded;
  logic          seed_err;
  logic [15:0]   word_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int unsigned m_lfsr = 0;
  int unsigned m_cnt  = 0;

  lfsr_stream_cipher_if #(.DATA_W(DW)) bus ();

  lfsr_stream_cipher #(
    .LFSR_W (LW),
    .TAPS   (16'hB400),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .bus       (bus),
    .seeded    (seeded),
    .seed_err  (seed_err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next DW keystream bits, bit i taken at step i; advances the model LFSR.
  function automatic logic [DW-1:0] next_keystream();
    int unsigned ks = 0;
    int unsigned b;
    for (int i = 0; i < DW; i++) begin
      b      = m_lfsr % 2;
      ks     = ks + b * (1 << i);
      m_lfsr = (m_lfsr / 2) ^ (b != 0 ? TAPS_INT : 0);
    end
    return DW'(ks);
  endfunction

  task automatic do_seed(input logic [LW-1:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    tick();
    seed_load = 1'b0;
    seed_in   = LW'($urandom);
    if (s != 0) begin
      m_lfsr = s;
      m_cnt  = 0;
    end
    #1;
  endtask

  // Push one word through; hold out_ready low for 'stall' cycles in OUT.
  task automatic run_word(input logic [DW-1:0] din, input int stall,
                          output logic [DW-1:0] got);
    logic [DW-1:0] exp;
    exp = din ^ next_keystream();
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = din;
    bus.out_ready = (stall == 0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom);
    repeat (DW - 1) tick();
    check("no_early_valid", bus.out_valid, 0);
    tick();
    check("out_valid_at_k_plus_dw", bus.out_valid, 1);
    check("out_data", bus.out_data, exp);
    got = bus.out_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid_held", bus.out_valid, 1);
      check("stall_data_held", bus.out_data, exp);
      check("stall_cnt_held", word_cnt, m_cnt);
    end
    bus.out_ready = 1'b1;
    tick();
    m_cnt = (m_cnt + 1) % 65536;
    check("valid_drop_after_xfer", bus.out_valid, 0);
    check("word_cnt", word_cnt, m_cnt);
  endtask

  initial begin
    logic [DW-1:0] got;
    logic [DW-1:0] plain [4];
    logic [DW-1:0] cipher [4];
    logic [LW-1:0] rseed;

    rst           = 1'b1;
    seed_load     = 1'b0;
    seed_in       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state.
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_seeded", seeded, 0);
    check("rst_seed_err", seed_err, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_in_ready", bus.in_ready, 0);

    // Unseeded: input must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    repeat (3) begin
      tick();
      check("unseeded_in_ready", bus.in_ready, 0);
      check("unseeded_out_valid", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;

    // Seed 1, known first word.
    do_seed(16'h0001);
    check("seeded_after_load", seeded, 1);
    check("word_cnt_after_load", word_cnt, 0);
    seed_load = 1'b1;
    #1;
    check("in_ready_blocked_by_seed_load", bus.in_ready, 0);
    seed_load = 1'b0;
    #1;
    run_word(8'h41, 0, got);
    check("known_word_0x41", got, 8'h40);
    run_word(8'h00, 0, got);
    check("word_cnt_two", word_cnt, 2);

    // Backpressure in OUT.
    run_word(DW'($urandom), 5, got);

    // Random words, keystream continuing across words.
    for (int i = 0; i < 6; i++) run_word(DW'($urandom), (i % 3), got);

    // Zero seed is rejected, then a good seed recovers.
    do_seed(16'h0000);
    check("zero_seed_err", seed_err, 1);
    check("zero_seed_seeded", seeded, 0);
    check("zero_seed_in_ready", bus.in_ready, 0);
    do_seed(16'h0001);
    check("reseed_err_clear", seed_err, 0);
    check("reseed_in_ready", bus.in_ready, 1);
    check("reseed_cnt_clear", word_cnt, 0);

    // seed_load in GEN cycle 3 discards the in-flight word.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    do_seed(16'h0001);
    check("discard_no_valid", bus.out_valid, 0);
    check("discard_cnt", word_cnt, 0);
    repeat (DW + 1) tick();
    check("discard_still_no_valid", bus.out_valid, 0);
    run_word(8'h41, 0, got);
    check("after_discard_0x41", got, 8'h40);

    // Round trip with a random seed: decrypt recovers plaintext.
    rseed = LW'($urandom_range(1, 16'hFFFF));
    do_seed(rseed);
    for (int i = 0; i < 4; i++) begin
      plain[i] = DW'($urandom);
      run_word(plain[i], 0, cipher[i]);
    end
    do_seed(rseed);
    for (int i = 0; i < 4; i++) begin
      run_word(cipher[i], 0, got);
      check("roundtrip_plain", got, plain[i]);
    end

    // Reset while a result waits in OUT.
    run_word(DW'($urandom), 0, got);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    repeat (DW) tick();
    check("pre_rst_in_out", bus.out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    m_lfsr = 0;
    m_cnt  = 0;
    check("rst_out_out_valid", bus.out_valid, 0);
    check("rst_out_out_data", bus.out_data, 0);
    check("rst_out_seeded", seeded, 0);
    check("rst_out_seed_err", seed_err, 0);
    check("rst_out_word_cnt", word_cnt, 0);
    check("rst_out_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    repeat (DW + 2) begin
      tick();
      check("post_rst_in_ready", bus.in_ready, 0);
    end
    check("post_rst_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    do_seed(16'h0001);
    run_word(8'h41, 0, got);
    check("post_rst_0x41", got, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
